// File: rtl/div_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : div_unit_if
// Description : Request/response bundle between the EX-stage pipeline and the
//               iterative divider. Pipeline side is the master.
// Revision    : 1.0 - initial release
// ============================================================================
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             START;
    logic [4:0]       SELECT;
    logic [WIDTH-1:0] DATA1;
    logic [WIDTH-1:0] DATA2;
    logic             FLUSH;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] RESULT;

    modport master (
        output START, SELECT, DATA1, DATA2, FLUSH,
        input  BUSY, DONE, RESULT
    );

    modport slave (
        input  START, SELECT, DATA1, DATA2, FLUSH,
        output BUSY, DONE, RESULT
    );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Iterative restoring divider for DIV/DIVU/REM/REMU. One
//               quotient bit per cycle, single-cycle fast paths for divide
//               by zero and signed overflow, registered RESULT with a
//               one-cycle DONE strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int WIDTH = 32
) (
    input  wire logic    CLK,
    input  wire logic    RESET,
    div_unit_if.slave    bus
);

    localparam int              CW      = $clog2(WIDTH + 1);
    localparam logic [4:0]      OP_DIV  = 5'b01111;
    localparam logic [4:0]      OP_DIVU = 5'b10000;
    localparam logic [4:0]      OP_REM  = 5'b10001;
    localparam logic [4:0]      OP_REMU = 5'b10010;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t             state_q,    state_d;
    logic [CW-1:0]      cnt_q,      cnt_d;
    logic [WIDTH:0]     rem_q,      rem_d;
    logic [WIDTH-1:0]   quot_q,     quot_d;
    logic [WIDTH-1:0]   dvsr_q,     dvsr_d;
    logic               is_rem_q,   is_rem_d;
    logic               neg_quot_q, neg_quot_d;
    logic               neg_rem_q,  neg_rem_d;
    logic [WIDTH-1:0]   result_q,   result_d;

    // Request decode
    logic             op_div, op_divu, op_rem, op_remu;
    logic             op_valid, op_signed, ready, accept;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign op_div    = (bus.SELECT == OP_DIV);
    assign op_divu   = (bus.SELECT == OP_DIVU);
    assign op_rem    = (bus.SELECT == OP_REM);
    assign op_remu   = (bus.SELECT == OP_REMU);
    assign op_valid  = op_div | op_divu | op_rem | op_remu;
    assign op_signed = op_div | op_rem;
    assign ready     = (state_q == S_IDLE) || (state_q == S_FIN);
    // FLUSH wins over a same-cycle START
    assign accept    = bus.START & ready & op_valid & ~bus.FLUSH;

    assign a_neg = op_signed & bus.DATA1[WIDTH-1];
    assign b_neg = op_signed & bus.DATA2[WIDTH-1];
    assign abs_a = a_neg ? -bus.DATA1 : bus.DATA1;
    assign abs_b = b_neg ? -bus.DATA2 : bus.DATA2;

    // One restoring step: shift {rem,quot} left, trial-subtract the divisor
    logic [WIDTH:0]   shifted, trial, rem_step;
    logic             qbit;
    logic [WIDTH-1:0] quot_step;

    assign shifted   = {rem_q[WIDTH-1:0], quot_q[WIDTH-1]};
    assign trial     = shifted - {1'b0, dvsr_q};
    assign qbit      = ~trial[WIDTH];
    assign rem_step  = qbit ? trial : shifted;
    assign quot_step = {quot_q[WIDTH-2:0], qbit};

    assign bus.BUSY   = (state_q == S_RUN);
    assign bus.DONE   = (state_q == S_FIN);
    assign bus.RESULT = result_q;

    // Next-state, datapath and result selection
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        dvsr_d     = dvsr_q;
        is_rem_d   = is_rem_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;

        if (bus.FLUSH) begin
            state_d = S_IDLE;
        end else if (accept) begin
            is_rem_d   = op_rem | op_remu;
            neg_quot_d = a_neg ^ b_neg;
            neg_rem_d  = a_neg;
            if (bus.DATA2 == '0) begin
                // Divide by zero: quotient all ones, remainder is the dividend
                result_d = (op_div | op_divu) ? ALL_ONE : bus.DATA1;
                state_d  = S_FIN;
            end else if (op_signed && bus.DATA1 == MIN_NEG && bus.DATA2 == ALL_ONE) begin
                // Signed overflow: quotient wraps to MIN_NEG, remainder zero
                result_d = op_div ? MIN_NEG : '0;
                state_d  = S_FIN;
            end else begin
                rem_d   = '0;
                quot_d  = abs_a;
                dvsr_d  = abs_b;
                cnt_d   = CW'(WIDTH);
                state_d = S_RUN;
            end
        end else begin
            case (state_q)
                S_RUN: begin
                    rem_d  = rem_step;
                    quot_d = quot_step;
                    cnt_d  = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = S_FIN;
                        if (is_rem_q) begin
                            result_d = neg_rem_q ? -rem_step[WIDTH-1:0] : rem_step[WIDTH-1:0];
                        end else begin
                            result_d = neg_quot_q ? -quot_step : quot_step;
                        end
                    end
                end
                S_FIN:   state_d = S_IDLE;
                S_IDLE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            dvsr_q     <= '0;
            is_rem_q   <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            dvsr_q     <= dvsr_d;
            is_rem_q   <= is_rem_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_unit
// Description : Directed and randomised stimulus for div_unit with an
//               expected-result queue popped on each DONE strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    localparam int          WIDTH   = 32;
    localparam logic [4:0]  OP_DIV  = 5'b01111;
    localparam logic [4:0]  OP_DIVU = 5'b10000;
    localparam logic [4:0]  OP_REM  = 5'b10001;
    localparam logic [4:0]  OP_REMU = 5'b10010;
    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    logic CLK = 1'b0;
    logic RESET;

    always #5 CLK = ~CLK;

    div_unit_if #(.WIDTH(WIDTH)) bus ();

    div_unit #(.WIDTH(WIDTH)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          t_acc       = 0;
    logic [31:0] exp_q[$];

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb, sr;
        sa = a;
        sb = b;
        sr = '0;
        case (sel)
            OP_DIV: begin
                if (b == 0)                          sr = -1;
                else if (a == MIN_NEG && b == '1)    sr = MIN_NEG;
                else                                 sr = sa / sb;
            end
            OP_REM: begin
                if (b == 0)                          sr = sa;
                else if (a == MIN_NEG && b == '1)    sr = 0;
                else                                 sr = sa % sb;
            end
            OP_DIVU: sr = (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REMU: sr = (b == 0) ? a : a % b;
            default: sr = '0;
        endcase
        return sr;
    endfunction

    // Present a START for one cycle, optionally enqueue the expected result,
    // then scramble the operands to show they are not used after accept.
    task automatic launch(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input bit push);
        bus.START  = 1'b1;
        bus.SELECT = sel;
        bus.DATA1  = a;
        bus.DATA2  = b;
        if (push) exp_q.push_back(exp_res);
        tick();
        t_acc      = cyc - 1;
        bus.START  = 1'b0;
        bus.SELECT = 5'($urandom_range(0, 31));
        bus.DATA1  = $urandom;
        bus.DATA2  = $urandom;
    endtask

    // Wait (bounded) for DONE, then check latency, result and BUSY behaviour
    task automatic wait_done(input int lat, input bit chk_busy);
        int          busy_n;
        logic [31:0] exp_res;
        busy_n = 0;
        while (!bus.DONE && (cyc - t_acc) < 80) begin
            if (bus.BUSY) busy_n++;
            tick();
        end
        check("done_latency", 32'(cyc - t_acc), 32'(lat));
        vectors++;
        assert (exp_q.size() != 0) else begin
            miscompares++;
            $error("FAIL scoreboard: observed empty queue expected pending result");
        end
        exp_res = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check("result", bus.RESULT, exp_res);
        check("busy_at_done", 32'(bus.BUSY), 32'd0);
        if (chk_busy) check("busy_cycles", 32'(busy_n), 32'(lat - 1));
    endtask

    // No DONE may appear for n cycles
    task automatic no_done(input string tag, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            if (bus.DONE) seen++;
            tick();
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [4:0]  sel;
        logic [31:0] a, b;
        int          lat;

        RESET      = 1'b0;
        bus.START  = 1'b0;
        bus.FLUSH  = 1'b0;
        bus.SELECT = '0;
        bus.DATA1  = '0;
        bus.DATA2  = '0;
        tick();
        tick();
        check("reset_busy",   32'(bus.BUSY), 32'd0);
        check("reset_done",   32'(bus.DONE), 32'd0);
        check("reset_result", bus.RESULT,    32'd0);
        RESET = 1'b1;
        tick();

        // Signed division and remainder
        launch(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1);
        wait_done(33, 1'b1);
        tick();
        check("fin_one_cycle", 32'(bus.DONE), 32'd0);
        launch(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1);
        wait_done(33, 1'b1);
        tick();

        // Unsigned division and remainder
        launch(OP_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 1'b1);
        wait_done(33, 1'b1);
        tick();
        launch(OP_REMU, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 1'b1);
        wait_done(33, 1'b1);
        tick();

        // Fast paths
        launch(OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
        wait_done(1, 1'b1);
        tick();
        launch(OP_REMU, 32'd5, 32'd0, 32'd5, 1'b1);
        wait_done(1, 1'b1);
        tick();
        launch(OP_DIV, MIN_NEG, 32'hFFFF_FFFF, MIN_NEG, 1'b1);
        wait_done(1, 1'b1);
        tick();
        launch(OP_REM, MIN_NEG, 32'hFFFF_FFFF, 32'd0, 1'b1);
        wait_done(1, 1'b1);
        tick();

        // Back-to-back: second START issued in the FIN cycle of the first
        launch(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b1);
        wait_done(33, 1'b1);
        launch(OP_REMU, 32'd100, 32'd7, 32'd2, 1'b1);
        wait_done(33, 1'b1);
        tick();

        // FLUSH in RUN cycle 10 aborts; RESULT keeps the previous value (2)
        launch(OP_DIVU, 32'hFFFF_FFFF, 32'h10, 32'd0, 1'b0);
        while ((cyc - t_acc) < 10) tick();
        bus.FLUSH = 1'b1;
        tick();
        bus.FLUSH = 1'b0;
        check("flush_busy",   32'(bus.BUSY), 32'd0);
        check("flush_done",   32'(bus.DONE), 32'd0);
        check("flush_result", bus.RESULT,    32'd2);
        no_done("flush_no_done", 40);
        check("flush_result_held", bus.RESULT, 32'd2);

        // FLUSH and START together in IDLE: not accepted
        bus.START  = 1'b1;
        bus.FLUSH  = 1'b1;
        bus.SELECT = OP_DIV;
        bus.DATA1  = 32'd5;
        bus.DATA2  = 32'd0;
        tick();
        bus.START = 1'b0;
        bus.FLUSH = 1'b0;
        check("flush_start_busy", 32'(bus.BUSY), 32'd0);
        no_done("flush_start_no_done", 5);
        check("flush_start_result", bus.RESULT, 32'd2);

        // Invalid SELECT ignored
        bus.START  = 1'b1;
        bus.SELECT = 5'b00001;
        bus.DATA1  = 32'd5;
        bus.DATA2  = 32'd0;
        tick();
        bus.START = 1'b0;
        check("badsel_busy", 32'(bus.BUSY), 32'd0);
        no_done("badsel_no_done", 5);

        // START while BUSY is ignored; in-flight result unaffected
        launch(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b1);
        tick();
        tick();
        bus.START  = 1'b1;
        bus.SELECT = OP_DIV;
        bus.DATA1  = 32'd5;
        bus.DATA2  = 32'd0;
        tick();
        bus.START = 1'b0;
        wait_done(33, 1'b0);
        tick();

        // Random operations against the reference model
        for (int i = 0; i < 8; i++) begin
            case (i % 4)
                0:       sel = OP_DIV;
                1:       sel = OP_DIVU;
                2:       sel = OP_REM;
                default: sel = OP_REMU;
            endcase
            a = $urandom;
            b = (i < 4) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (i == 6) b = 32'hFFFF_FFFF;
            lat = (b == 0) ? 1 : 33;
            launch(sel, a, b, model(sel, a, b), 1'b1);
            wait_done(lat, 1'b1);
            tick();
        end

        // Reset mid-operation
        launch(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0);
        tick();
        tick();
        tick();
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
        check("midreset_busy",   32'(bus.BUSY), 32'd0);
        check("midreset_done",   32'(bus.DONE), 32'd0);
        check("midreset_result", bus.RESULT,    32'd0);
        no_done("midreset_no_done", 40);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
